// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared definitions for the instruction fetch unit.
// Holds word width, memory size, fetch stride, the FSM state encoding and
// the range check applied before every fetch strobe.
package fetch_unit_pkg;

    localparam int WORD         = 16;
    localparam int MEMSIZE      = 256;
    localparam int FETCH_STRIDE = 2;

    // Highest pc whose immediate word (pc+1) still lies inside memory.
    localparam logic [WORD-1:0] LAST_PC = WORD'(MEMSIZE - FETCH_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_CAP   = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    function automatic logic pc_in_range(input logic [WORD-1:0] pc);
        return pc <= LAST_PC;
    endfunction

endpackage

// File: rtl/fetch_unit_buf.sv
// fetch_unit_buf -- fetch packet register plus its valid bit.
// Ports:
//   clk, rst            clock, async active-high reset
//   load                capture instr/imm/data/pc and set valid
//   clear               drop the packet (clear has priority over load)
//   instr, imm, data    memory words to capture
//   pc                  address the packet was fetched from
//   valid               packet valid
//   f_instr, f_imm, f_data, f_pc   buffered packet
module fetch_unit_buf
    import fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [WORD-1:0]        instr,
    input  logic [WORD-1:0]        imm,
    input  logic signed [WORD-1:0] data,
    input  logic [WORD-1:0]        pc,
    output logic                   valid,
    output logic [WORD-1:0]        f_instr,
    output logic [WORD-1:0]        f_imm,
    output logic signed [WORD-1:0] f_data,
    output logic [WORD-1:0]        f_pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            f_instr <= '0;
            f_imm   <= '0;
            f_data  <= '0;
            f_pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            f_instr <= instr;
            f_imm   <= imm;
            f_data  <= data;
            f_pc    <= pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetcher with a one-entry packet buffer.
// Each packet is (instr, imm, memory[imm]) read from pc and pc+1 of a
// registered memory; pc then advances by FETCH_STRIDE.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    level, releases the unit from IDLE
//   redirect, redirect_addr  one-cycle pc change request and target
//   fetch, fetch_addr        memory strobe and address (fetch_addr == pc)
//   instr_in, imm_in, data_in  registered memory read data
//   f_valid, f_ready         packet handshake towards decode
//   f_instr, f_imm, f_data, f_pc  buffered packet and its address
//   fault                    sticky out-of-range fetch flag
//
// state | meaning
// IDLE  | waiting for start
// REQ   | strobe fetch at pc (or fault if pc+1 is outside memory)
// CAP   | memory data valid, capture packet, advance pc
// HOLD  | packet presented until decode accepts it
// FAULT | out-of-range fetch seen, only reset leaves
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   redirect,
    input  logic [WORD-1:0]        redirect_addr,
    output logic                   fetch,
    output logic [WORD-1:0]        fetch_addr,
    input  logic [WORD-1:0]        instr_in,
    input  logic [WORD-1:0]        imm_in,
    input  logic signed [WORD-1:0] data_in,
    output logic                   f_valid,
    input  logic                   f_ready,
    output logic [WORD-1:0]        f_instr,
    output logic [WORD-1:0]        f_imm,
    output logic signed [WORD-1:0] f_data,
    output logic [WORD-1:0]        f_pc,
    output logic                   fault
);

    state_t          state, state_nx;
    logic [WORD-1:0] pc, pc_nx;
    logic            buf_load, buf_clear;
    logic            fault_set;

    assign fetch_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        fetch     = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        fault_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_nx = redirect_addr;
                end
                if (start) begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                // An out-of-range pc never reaches the memory, even when a
                // redirect arrives in the same cycle.
                if (!pc_in_range(pc)) begin
                    fault_set = 1'b1;
                    state_nx  = S_FAULT;
                end else begin
                    fetch = 1'b1;
                    if (redirect) begin
                        // Strobe already issued; its data is simply never captured.
                        pc_nx     = redirect_addr;
                        buf_clear = 1'b1;
                        state_nx  = S_REQ;
                    end else begin
                        state_nx = S_CAP;
                    end
                end
            end
            S_CAP: begin
                if (redirect) begin
                    pc_nx     = redirect_addr;
                    buf_clear = 1'b1;
                    state_nx  = S_REQ;
                end else begin
                    buf_load = 1'b1;
                    pc_nx    = pc + WORD'(FETCH_STRIDE);
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nx     = redirect_addr;
                    buf_clear = 1'b1;
                    state_nx  = S_REQ;
                end else if (f_valid && f_ready) begin
                    buf_clear = 1'b1;
                    state_nx  = S_REQ;
                end
            end
            S_FAULT: begin
                if (redirect) begin
                    pc_nx = redirect_addr;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    fetch_unit_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .clear   (buf_clear),
        .instr   (instr_in),
        .imm     (imm_in),
        .data    (data_in),
        .pc      (pc),
        .valid   (f_valid),
        .f_instr (f_instr),
        .f_imm   (f_imm),
        .f_data  (f_data),
        .f_pc    (f_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed and randomized checks of fetch_unit against a
// packet-level reference: the next packet handed to decode is always the
// one at the architectural pc, which advances by 2 per accepted packet and
// jumps on redirect.
module tb_fetch_unit;
    import fetch_unit_pkg::MEMSIZE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        fetch;
    logic [15:0] fetch_addr;
    logic [15:0] instr_in = '0;
    logic [15:0] imm_in = '0;
    logic signed [15:0] data_in = '0;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [15:0] f_instr, f_imm, f_pc;
    logic signed [15:0] f_data;
    logic        fault;

    logic [15:0] mem [0:MEMSIZE-1];
    int tests = 0;
    int fails = 0;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fetch         (fetch),
        .fetch_addr    (fetch_addr),
        .instr_in      (instr_in),
        .imm_in        (imm_in),
        .data_in       (data_in),
        .f_valid       (f_valid),
        .f_ready       (f_ready),
        .f_instr       (f_instr),
        .f_imm         (f_imm),
        .f_data        (f_data),
        .f_pc          (f_pc),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_at(input logic [15:0] a);
        return mem[int'(a) % MEMSIZE];
    endfunction

    // Registered memory: data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (fetch) begin
            instr_in <= mem_at(fetch_addr);
            imm_in   <= mem_at(fetch_addr + 16'd1);
            data_in  <= mem_at(mem_at(fetch_addr + 16'd1));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_packet(input string tag, input logic [15:0] a);
        chk1 ({tag, "_valid"}, f_valid, 1'b1);
        chk16({tag, "_pc"},    f_pc, a);
        chk16({tag, "_instr"}, f_instr, mem_at(a));
        chk16({tag, "_imm"},   f_imm, mem_at(a + 16'd1));
        chk16({tag, "_data"},  f_data, mem_at(mem_at(a + 16'd1)));
    endtask

    initial begin
        logic [15:0] exp_pc;
        int          accepted;
        int          nfetch;
        logic        prev_redirect;

        for (int i = 0; i < MEMSIZE; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h6600;
        mem[1] = 16'h0001;

        // Reset state
        #12;
        chk1 ("rst_fetch", fetch, 1'b0);
        chk1 ("rst_valid", f_valid, 1'b0);
        chk1 ("rst_fault", fault, 1'b0);
        chk16("rst_pc", fetch_addr, 16'h0000);
        chk16("rst_instr", f_instr, 16'h0000);
        chk16("rst_fpc", f_pc, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First packet from address 0
        start = 1'b1;
        step;
        chk1 ("first_fetch", fetch, 1'b1);
        chk16("first_addr", fetch_addr, 16'h0000);
        step;
        chk1 ("cap_no_fetch", fetch, 1'b0);
        chk1 ("cap_no_valid", f_valid, 1'b0);
        step;
        check_packet("first", 16'h0000);
        chk16("first_instr_lit", f_instr, 16'h6600);
        chk16("first_imm_lit", f_imm, 16'h0001);
        chk16("first_pc_adv", fetch_addr, 16'h0002);

        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step;
            chk1 ("stall_no_fetch", fetch, 1'b0);
            chk16("stall_instr", f_instr, 16'h6600);
            chk16("stall_pc", f_pc, 16'h0000);
            chk1 ("stall_valid", f_valid, 1'b1);
        end
        f_ready = 1'b1;
        step;
        f_ready = 1'b0;
        chk1 ("accept_fetch", fetch, 1'b1);
        chk16("accept_addr", fetch_addr, 16'h0002);
        chk1 ("accept_drop_valid", f_valid, 1'b0);
        step;
        step;
        check_packet("second", 16'h0002);

        // Redirect during CAP discards the in-flight packet
        f_ready = 1'b1;
        step;
        f_ready = 1'b0;
        chk16("third_addr", fetch_addr, 16'h0004);
        step;
        redirect = 1'b1;
        redirect_addr = 16'd9;
        step;
        redirect = 1'b0;
        chk1 ("redir_no_valid", f_valid, 1'b0);
        chk1 ("redir_fetch", fetch, 1'b1);
        chk16("redir_addr", fetch_addr, 16'd9);
        step;
        chk1 ("redir_cap_no_valid", f_valid, 1'b0);
        step;
        check_packet("redir", 16'd9);

        // Randomized traffic: random ready, occasional redirects
        exp_pc = 16'd9;
        accepted = 0;
        prev_redirect = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (prev_redirect) chk1("rnd_redir_drop", f_valid, 1'b0);
            if (f_valid) check_packet("rnd", exp_pc);
            if (fetch) chk16("rnd_fetch_addr", fetch_addr, exp_pc);
            chk1("rnd_fault", fault, 1'b0);
            f_ready = ($urandom_range(0, 1) == 1);
            redirect = ($urandom_range(0, 7) == 0);
            redirect_addr = 16'($urandom_range(0, 120));
            if (redirect) begin
                exp_pc = redirect_addr;
            end else if (f_valid && f_ready) begin
                exp_pc = exp_pc + 16'd2;
                accepted++;
            end
            prev_redirect = redirect;
            step;
        end
        redirect = 1'b0;
        f_ready = 1'b0;
        chk1("rnd_progress", accepted > 20, 1'b1);

        // Throughput: one packet per 3 cycles under continuous ready
        redirect = 1'b1;
        redirect_addr = 16'd20;
        step;
        redirect = 1'b0;
        f_ready = 1'b1;
        nfetch = 0;
        for (int c = 0; c < 12; c++) begin
            if (fetch) begin
                chk16("tput_addr", fetch_addr, 16'(20 + 2 * nfetch));
                nfetch++;
            end
            step;
        end
        chk16("tput_count", 16'(nfetch), 16'd4);
        f_ready = 1'b0;

        // Out-of-range redirect target -> FAULT, sticky until reset
        redirect = 1'b1;
        redirect_addr = 16'(MEMSIZE - 1);
        step;
        redirect = 1'b0;
        chk1 ("oor_no_fetch", fetch, 1'b0);
        step;
        chk1 ("fault_set", fault, 1'b1);
        chk1 ("fault_no_fetch", fetch, 1'b0);
        redirect = 1'b1;
        redirect_addr = 16'd4;
        step;
        redirect = 1'b0;
        chk16("fault_redir_pc", fetch_addr, 16'd4);
        for (int c = 0; c < 4; c++) begin
            chk1("fault_sticky", fault, 1'b1);
            chk1("fault_fetch_off", fetch, 1'b0);
            chk1("fault_no_valid", f_valid, 1'b0);
            step;
        end
        rst = 1'b1;
        #1;
        chk1 ("fault_cleared", fault, 1'b0);
        chk16("fault_rst_pc", fetch_addr, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;

        // Redirect in IDLE moves pc only
        redirect = 1'b1;
        redirect_addr = 16'd6;
        step;
        redirect = 1'b0;
        chk16("idle_redir_pc", fetch_addr, 16'd6);
        chk1 ("idle_redir_no_fetch", fetch, 1'b0);
        step;
        chk1 ("idle_stays", fetch, 1'b0);
        start = 1'b1;
        step;
        chk1 ("idle_start_fetch", fetch, 1'b1);
        chk16("idle_start_addr", fetch_addr, 16'd6);
        step;
        step;
        check_packet("idle", 16'd6);

        // Asynchronous reset while holding a valid packet
        #2;
        rst = 1'b1;
        #1;
        chk1 ("arst_valid", f_valid, 1'b0);
        chk16("arst_pc", fetch_addr, 16'h0000);
        chk16("arst_fpc", f_pc, 16'h0000);
        chk16("arst_instr", f_instr, 16'h0000);
        chk1 ("arst_fetch", fetch, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the first fetch address after reset.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-004 Port start, input, 1, SHALL be a level that releases the unit from IDLE.
REQ-005 Port redirect, input, 1, SHALL be a one-cycle request to change the PC.
REQ-006 Port redirect_addr, input, `WORD, SHALL be the absolute redirect target.
REQ-007 Port fetch, output, 1, SHALL drive the memory fetch strobe.
REQ-008 Port fetch_addr, output, `WORD, SHALL drive the memory fetch address and equal pc at all times.
REQ-009 Ports instr_in, imm_in and data_in, input, `WORD each (data_in signed), SHALL carry memory's registered instruction word, immediate word and memory[imm] respectively.
REQ-010 Port f_valid, output, 1, SHALL flag that the buffered fetch packet is valid.
REQ-011 Port f_ready, input, 1, SHALL be the decode stage's acceptance signal.
REQ-012 Ports f_instr, f_imm, f_data and f_pc, output, `WORD each, SHALL carry the buffered packet and the address it was fetched from.
REQ-013 Port fault, output, 1, SHALL be a sticky out-of-range fetch flag.

Function
REQ-014 FSM SHALL have states IDLE, REQ, CAP, HOLD and FAULT.
REQ-015 IDLE: SHALL go to REQ when start=1.
REQ-016 REQ: SHALL set fetch=1 for exactly this cycle; next state CAP.
REQ-017 CAP: SHALL sample instr_in/imm_in/data_in into f_instr/f_imm/f_data, set f_pc<=pc, f_valid<=1 and pc<=pc+2; next state HOLD.
REQ-018 Mem latency: data sampled in CAP SHALL be the data the memory registered at the end of the REQ cycle, one cycle after the strobe.
REQ-019 HOLD: if f_valid&&f_ready, SHALL clear f_valid and go to REQ on the same edge; otherwise the packet SHALL be held stable.
REQ-020 Throughput SHALL be one packet per 3 cycles under continuous f_ready.
REQ-021 fetch SHALL be 0 in every state except REQ.
REQ-022 redirect=1 in REQ, CAP or HOLD SHALL: set pc<=redirect_addr, clear f_valid, discard in-flight data and go to REQ; it has priority over the handshake and the CAP capture.
REQ-023 redirect in IDLE or FAULT SHALL update pc only, with no state change.
REQ-024 pc SHALL increment modulo 2^`WORD.
REQ-025 On entering REQ with pc > `MEMSIZE-2 (imm word out of range), fetch SHALL stay 0, fault<=1 and the state SHALL go to FAULT.
REQ-026 FAULT SHALL be left only by rst.
REQ-027 Odd redirect targets SHALL be legal.

Reset
REQ-028 rst SHALL force state=IDLE, pc=RESET_PC, fetch=0, f_valid=0, fault=0 and f_instr/f_imm/f_data/f_pc=0, immediately and regardless of clk.
REQ-029 rst asserted mid-packet SHALL drop the packet with no partial handshake.

Structure
REQ-030 WORD and MEMSIZE SHALL come from the shared fmt.v header, which SHALL also hold FETCH_STRIDE=2 and the FSM state encodings.
REQ-031 The unit SHALL be a single module; an optional sub-module fetch_buf SHALL hold the packet register and valid bit.

Verification
REQ-032 Reset then start=1 with mem[0]=16'h6600 and mem[1]=16'h0001 -> fetch pulse at address 0; two cycles later f_valid=1, f_instr=16'h6600, f_imm=1, f_pc=0; pc=2.
REQ-033 Hold f_ready=0 for 5 cycles -> packet stable and no fetch pulse; f_ready=1 -> next fetch_addr=2 on the following cycle.
REQ-034 redirect=1 with redirect_addr=9 during CAP -> no f_valid for the old packet; next fetch at 9, f_pc=9.
REQ-035 redirect_addr=`MEMSIZE-1 -> fault=1, state FAULT, fetch never asserted; only rst clears fault.
REQ-036 Assert rst while in HOLD with f_valid=1 -> f_valid=0 and pc=RESET_PC before the next clk edge.
